fifo_write_arbiter: RTL and testbench

- Write-side scheduler for the asynchronous FIFO; lives entirely in the write clock domain.
- Shares the single FIFO write port (w_en/data_in, back-pressured by full) between NUM_REQ requesters.
- Uses round-robin arbitration with a bounded burst lock, so one requester cannot starve the others.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/rr_priority_picker.sv | 29 ++
 rtl/fifo_write_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-side arbiter.
// Widths for the default build plus functions for other parameter sets.
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 4;
    localparam int GNT_ID_W      = $clog2(NUM_REQ_DEF);
    localparam int BURST_W       = $clog2(MAX_BURST_DEF) + 1;

    function automatic int gnt_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int burst_w(input int m);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request after the last-served index,
// wrapping around; purely combinational.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IW      = gnt_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [IW-1:0]      o_pick,
    output logic               o_found
);

    always_comb begin : p_scan
        int idx;
        idx     = 0;
        o_pick  = '0;
        o_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(i_last) + k) % NUM_REQ;
            if (!o_found && i_req[idx]) begin
                o_found = 1'b1;
                o_pick  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Write-domain scheduler sharing one FIFO write port between requesters
// using round-robin grants with a bounded burst length.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = MAX_BURST_DEF,
    parameter int CNT_WIDTH  = 16,
    parameter int IW         = gnt_id_w(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          gnt_valid,
    output logic [IW-1:0]                 gnt_id,
    output logic [CNT_WIDTH-1:0]          beat_count
);

    localparam int BW = burst_w(MAX_BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

    arb_state_t           r_state;
    logic [IW-1:0]        r_gnt_id;
    logic [IW-1:0]        r_last;
    logic [BW-1:0]        r_burst;
    logic [CNT_WIDTH-1:0] r_beat_count;

    logic          w_gnt_valid;
    logic          w_xfer;
    logic          w_release;
    logic          w_found;
    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_pick_last;

    assign w_gnt_valid = (r_state == GRANT);
    assign w_xfer      = w_gnt_valid & req_valid[r_gnt_id] & ~full;
    assign w_release   = ~req_valid[r_gnt_id] |
                         (w_xfer & (r_burst == LAST_BEAT));
    // On release the grantee becomes "last", so the scan starts after it
    assign w_pick_last = w_gnt_valid ? r_gnt_id : r_last;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .i_req   (req_valid),
        .i_last  (w_pick_last),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state      <= IDLE;
            r_gnt_id     <= '0;
            r_last       <= LAST_REQ;
            r_burst      <= '0;
            r_beat_count <= '0;
        end else begin
            if (w_xfer) r_beat_count <= r_beat_count + 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state  <= GRANT;
                        r_gnt_id <= w_pick;
                        r_burst  <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_last <= r_gnt_id;
                        if (w_found) begin
                            r_gnt_id <= w_pick;
                            r_burst  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_xfer) begin
                        r_burst <= r_burst + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        data_in   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_valid && (r_gnt_id == IW'(i))) begin
                req_ready[i] = ~full;
                data_in      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_en       = w_xfer;
    assign gnt_valid  = w_gnt_valid;
    assign gnt_id     = r_gnt_id;
    assign beat_count = r_beat_count;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized bench for fifo_write_arbiter against a
// cycle-level reference model of the round-robin burst rules.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = NUM_REQ_DEF;
    localparam int DW = 8;
    localparam int MB = MAX_BURST_DEF;
    localparam int CW = 16;

    logic                wclk = 1'b0;
    logic                wrst_n = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N*DW-1:0]     req_data = '0;
    logic                full = 1'b0;
    logic [N-1:0]        req_ready;
    logic                w_en;
    logic [DW-1:0]       data_in;
    logic                gnt_valid;
    logic [GNT_ID_W-1:0] gnt_id;
    logic [CW-1:0]       beat_count;

    int n_chk = 0;
    int n_pass = 0;

    bit m_gv;
    int m_gid;
    int m_burst;
    int m_last;
    int m_cnt;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .full       (full),
        .w_en       (w_en),
        .data_in    (data_in),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .beat_count (beat_count)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] rv, input int last);
        for (int k = 1; k <= N; k++)
            if (rv[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_gv = 0; m_gid = 0; m_burst = 0; m_last = N - 1; m_cnt = 0;
    endtask

    function automatic bit model_xfer();
        return m_gv && req_valid[m_gid] && !full;
    endfunction

    task automatic check_outputs();
        logic [DW-1:0] ed;
        logic [N-1:0]  er;
        ed = m_gv ? req_data[m_gid*DW +: DW] : '0;
        er = (m_gv && !full) ? N'(1 << m_gid) : '0;
        chk("w_en", w_en, model_xfer());
        chk("data_in", data_in, ed);
        chk("req_ready", req_ready, er);
        chk("gnt_valid", gnt_valid, m_gv);
        chk("gnt_id", gnt_id, m_gid);
        chk("beat_count", beat_count, m_cnt & 32'hFFFF);
    endtask

    task automatic model_step();
        bit x;
        int p;
        x = model_xfer();
        if (x) m_cnt++;
        if (!m_gv) begin
            p = pick(req_valid, m_last);
            if (p >= 0) begin m_gv = 1; m_gid = p; m_burst = 0; end
        end else if (!req_valid[m_gid] || (x && m_burst == MB - 1)) begin
            m_last = m_gid;
            p = pick(req_valid, m_last);
            if (p >= 0) begin m_gid = p; m_burst = 0; end
            else m_gv = 0;
        end else if (x) begin
            m_burst++;
        end
    endtask

    task automatic step();
        @(negedge wclk);
        check_outputs();
        model_step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        wrst_n = 1'b0;
        model_reset();
        @(posedge wclk);
        #1;
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        model_reset();
        req_data = {$urandom};
        #1;
        chk("rst_gnt_valid", gnt_valid, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_beat_count", beat_count, 0);
        chk("rst_w_en", w_en, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge wclk);
        #1;
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;

        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        step();
        chk("t1_gnt_valid", gnt_valid, 1);
        chk("t1_gnt_id", gnt_id, 0);
        chk("t1_w_en", w_en, 1);
        chk("t1_data_in", data_in, 8'hA5);
        step();
        req_valid = '0;
        #1;
        chk("t1_beat_count", beat_count, 1);
        step();
        step();

        do_reset();
        req_valid = 4'b1111;
        step();
        for (int i = 0; i < 20; i++) begin
            chk("rr_order", gnt_id, (i / 4) % 4);
            chk("rr_no_gap", w_en, 1);
            step();
            if (i == 15) chk("rr_beat16", beat_count, 16);
        end

        do_reset();
        req_valid = 4'b0010;
        step();
        step();
        req_valid = 4'b0011;
        full = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("full_w_en", w_en, 0);
            chk("full_ready", req_ready, 0);
            chk("full_gnt_id", gnt_id, 1);
            step();
        end
        full = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("full_resume_id", gnt_id, 1);
            chk("full_resume_wen", w_en, 1);
            step();
        end
        chk("full_burst_end", gnt_id, 0);

        do_reset();
        req_valid = 4'b0100;
        step();
        step();
        step();
        req_valid = 4'b0001;
        #1;
        chk("drop_w_en", w_en, 0);
        chk("drop_gnt_id", gnt_id, 2);
        step();
        chk("regrant_id", gnt_id, 0);
        chk("regrant_wen", w_en, 1);
        chk("regrant_data", data_in, req_data[7:0]);
        for (int i = 0; i < 4; i++) begin
            chk("regrant_burst", w_en, 1);
            step();
        end

        do_reset();
        req_valid = 4'b1000;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("solo_id", gnt_id, 3);
            chk("solo_wen", w_en, 1);
            step();
        end

        #2;
        wrst_n = 1'b0;
        #1;
        chk("arst_gnt_valid", gnt_valid, 0);
        chk("arst_w_en", w_en, 0);
        chk("arst_beat_count", beat_count, 0);
        model_reset();
        req_valid = '0;
        @(posedge wclk);
        #1;
        chk("arst_hold_wen", w_en, 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        req_valid = 4'b1111;
        step();
        chk("arst_prio0", gnt_id, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) req_valid = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_data = {$urandom};
            full = ($urandom_range(0, 3) == 0);
            step();
        end
        full = 1'b0;
        req_valid = '0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
